// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanned, debounced 4x4 hex keypad front end.
// One row is driven low at a time and the active-low columns are sampled at
// the end of each row slot. A full four-row frame yields one candidate key
// (lowest code wins) and a frame-rate FSM debounces press and release before
// reporting the key over a valid/ack handshake and shifting it into a
// 16-bit hex entry word.
module keypad_scanner #(
  parameter int CLK_DIV        = 50000, // clk cycles per row slot, >= 2
  parameter int DEBOUNCE_SCANS = 10     // identical frames to accept, >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cols_n,
  output logic [3:0]  rows_n,
  output logic [3:0]  key_code,
  output logic        key_valid,
  input  logic        key_ack,
  output logic        key_overrun,
  output logic [15:0] entry_value,
  input  logic        entry_clear
);

  // Divider and debounce counter widths. The debounce counter must be able
  // to hold DEBOUNCE_SCANS itself, since that is the terminal value.
  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_TARGET = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    DEBOUNCE    = 2'd1,
    HELD        = 2'd2,
    RELEASE_DEB = 2'd3
  } state_t;

  // ---------------------------------------------------------------------
  // Column synchronizer
  // ---------------------------------------------------------------------
  logic [3:0] cols_meta_reg;
  logic [3:0] cols_s;

  // Two-flop synchronizer; reset to the released (pulled-up) level so no
  // phantom key is seen before the first real sample arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cols_meta_reg <= 4'hF;
      cols_s        <= 4'hF;
    end else begin
      cols_meta_reg <= cols_n;
      cols_s        <= cols_meta_reg;
    end
  end

  // ---------------------------------------------------------------------
  // Row slot divider and row scan
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] div_cnt_reg;
  logic [1:0]       row_idx_reg;
  logic             tick;
  logic             frame_end;

  assign tick      = (div_cnt_reg == DIV_LAST);
  assign frame_end = tick && (row_idx_reg == 2'd3);

  // Free-running slot divider: tick on the last count of each row slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= '0;
    end else if (tick) begin
      div_cnt_reg <= '0;
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  // Row index advances after its slot has been sampled; wraps 3 -> 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_idx_reg <= 2'd0;
    end else if (tick) begin
      row_idx_reg <= row_idx_reg + 2'd1;
    end
  end

  assign rows_n = ~(4'b0001 << row_idx_reg);

  // ---------------------------------------------------------------------
  // Per-row column decode and frame candidate
  // ---------------------------------------------------------------------
  logic       row_hit;
  logic [1:0] row_col;

  // Lowest pressed column of the currently driven row (scan descends so the
  // last assignment, the lowest column, wins).
  always_comb begin
    row_hit = 1'b0;
    row_col = 2'd0;
    for (int c = 3; c >= 0; c--) begin
      if (!cols_s[c]) begin
        row_hit = 1'b1;
        row_col = 2'(c);
      end
    end
  end

  logic       frame_found_reg;
  logic [3:0] frame_code_reg;

  // Remember the first hit of the frame (lowest row); rows are visited in
  // ascending order so the first one recorded is the lowest code.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_found_reg <= 1'b0;
      frame_code_reg  <= 4'd0;
    end else if (tick) begin
      if (frame_end) begin
        frame_found_reg <= 1'b0;
        frame_code_reg  <= 4'd0;
      end else if (!frame_found_reg && row_hit) begin
        frame_found_reg <= 1'b1;
        frame_code_reg  <= {row_idx_reg, row_col};
      end
    end
  end

  // Candidate for the frame that completes this cycle: an earlier row's hit
  // has priority, otherwise the row-3 sample being taken right now.
  logic       cand_valid;
  logic [3:0] cand_code;

  assign cand_valid = frame_found_reg || row_hit;
  assign cand_code  = frame_found_reg ? frame_code_reg : {2'd3, row_col};

  // ---------------------------------------------------------------------
  // Debounce FSM (evaluated only at frame end)
  // ---------------------------------------------------------------------
  state_t           state_reg;
  state_t           state_next;
  logic [3:0]       cand_reg;
  logic [3:0]       cand_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;
  logic             accept;
  logic [3:0]       accept_code;

  assign cnt_inc = cnt_reg + CNT_ONE;

  // FSM state, candidate and frame counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cand_reg  <= 4'd0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cand_reg  <= cand_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; accept fires on the frame that completes a press.
  always_comb begin
    state_next  = state_reg;
    cand_next   = cand_reg;
    cnt_next    = cnt_reg;
    accept      = 1'b0;
    accept_code = cand_reg;
    if (frame_end) begin
      case (state_reg)
        IDLE: begin
          if (cand_valid) begin
            cand_next = cand_code;
            cnt_next  = CNT_ONE;
            if (DEBOUNCE_SCANS == 1) begin
              accept      = 1'b1;
              accept_code = cand_code;
              state_next  = HELD;
            end else begin
              state_next = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (!cand_valid) begin
            state_next = IDLE;
          end else if (cand_code != cand_reg) begin
            // A different key restarts the count on that key.
            cand_next = cand_code;
            cnt_next  = CNT_ONE;
          end else if (cnt_inc == DEB_TARGET) begin
            accept     = 1'b1;
            state_next = HELD;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        HELD: begin
          // Only an empty frame starts release; other keys are ignored.
          if (!cand_valid) begin
            cnt_next   = CNT_ONE;
            state_next = (DEBOUNCE_SCANS == 1) ? IDLE : RELEASE_DEB;
          end
        end
        RELEASE_DEB: begin
          if (cand_valid) begin
            // Contact bounce during release: return to HELD, no re-report.
            state_next = HELD;
          end else if (cnt_inc == DEB_TARGET) begin
            state_next = IDLE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Handshake and entry word
  // ---------------------------------------------------------------------
  logic [3:0]  key_code_reg;
  logic        key_valid_reg;
  logic        key_overrun_reg;
  logic [15:0] entry_value_reg;

  // Key report: a new accept always wins over a coincident ack; overrun
  // flags a still-pending key being replaced without acknowledgement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code_reg    <= 4'd0;
      key_valid_reg   <= 1'b0;
      key_overrun_reg <= 1'b0;
    end else begin
      key_overrun_reg <= accept && key_valid_reg && !key_ack;
      if (accept) begin
        key_code_reg  <= accept_code;
        key_valid_reg <= 1'b1;
      end else if (key_ack) begin
        key_valid_reg <= 1'b0;
      end
    end
  end

  // Hex entry shift register; a clear coincident with an accept leaves only
  // the new digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_value_reg <= 16'h0000;
    end else if (accept) begin
      if (entry_clear) begin
        entry_value_reg <= {12'h000, accept_code};
      end else begin
        entry_value_reg <= {entry_value_reg[11:0], accept_code};
      end
    end else if (entry_clear) begin
      entry_value_reg <= 16'h0000;
    end
  end

  assign key_code    = key_code_reg;
  assign key_valid   = key_valid_reg;
  assign key_overrun = key_overrun_reg;
  assign entry_value = entry_value_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with CLK_DIV=4 and
// DEBOUNCE_SCANS=2 (16-cycle frame). A small keypad model closes one key
// contact between the selected row and column.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  cols_n;
  logic [3:0]  rows_n;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_ack = 1'b0;
  logic        key_overrun;
  logic [15:0] entry_value;
  logic        entry_clear = 1'b0;

  // Keypad model: contact closes key key_sel (row = key_sel/4, col = key_sel%4).
  logic        contact = 1'b0;
  logic [3:0]  key_sel = 4'd0;
  logic [3:0]  row_pat;
  logic [3:0]  col_pat;

  assign row_pat = ~(4'b0001 << key_sel[3:2]);
  assign col_pat = ~(4'b0001 << key_sel[1:0]);
  assign cols_n  = (contact && (rows_n == row_pat)) ? col_pat : 4'hF;

  keypad_scanner #(
    .CLK_DIV        (4),
    .DEBOUNCE_SCANS (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cols_n      (cols_n),
    .rows_n      (rows_n),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_overrun (key_overrun),
    .entry_value (entry_value),
    .entry_clear (entry_clear)
  );

  always #5 clk = ~clk;

  // Cycle count since reset release: frame ends fall on multiples of 16.
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Overrun pulse counter, sampled on the falling edge.
  int overrun_cnt = 0;
  always @(negedge clk) begin
    if (key_overrun === 1'b1) overrun_cnt <= overrun_cnt + 1;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %s: observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (key_valid !== 1'b1 && n < 51) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic align_frame(output int base);
    int n;
    n = 0;
    while ((cyc % 16) != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    base = cyc;
  endtask

  task automatic wait_cyc(input int target);
    int n;
    n = 0;
    while (cyc != target && n < 80) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic ack_pulse(input string tag);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check(tag, {15'd0, key_valid}, 16'd0);
  endtask

  // Press, expect acceptance, hold 10 frames, ack, release.
  task automatic do_key(input logic [3:0] code, input string tag);
    int n;
    n = 0;
    key_sel = code;
    contact = 1'b1;
    while (key_valid !== 1'b1 && n < 51) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {15'd0, key_valid}, 16'd1);
    check({tag, "_code"}, {12'd0, key_code}, {12'd0, code});
    repeat (160 - n) @(negedge clk);
    ack_pulse({tag, "_ack"});
    contact = 1'b0;
    repeat (64) @(negedge clk);
  endtask

  logic [3:0] rows_tab [4];
  int base;
  int ov0;

  initial begin
    rows_tab[0] = 4'b1110;
    rows_tab[1] = 4'b1101;
    rows_tab[2] = 4'b1011;
    rows_tab[3] = 4'b0111;

    // Reset state
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rows", {12'd0, rows_n}, 16'h000E);
    check("rst_code", {12'd0, key_code}, 16'd0);
    check("rst_valid", {15'd0, key_valid}, 16'd0);
    check("rst_overrun", {15'd0, key_overrun}, 16'd0);
    check("rst_entry", entry_value, 16'h0000);
    rst_n = 1'b1;

    // Row scan sequence with no key: each row 4 cycles, repeating
    for (int i = 1; i <= 32; i++) begin
      @(negedge clk);
      check($sformatf("scan_rows_%0d", i), {12'd0, rows_n}, {12'd0, rows_tab[(i / 4) % 4]});
      check($sformatf("scan_valid_%0d", i), {15'd0, key_valid}, 16'd0);
    end
    check("scan_entry", entry_value, 16'h0000);

    // Key 9 (row 2, col 1) held: accepted within 51 cycles, then no repeat
    key_sel = 4'd9;
    contact = 1'b1;
    wait_valid();
    check("k9_valid", {15'd0, key_valid}, 16'd1);
    check("k9_code", {12'd0, key_code}, 16'd9);
    check("k9_entry", entry_value, 16'h0009);
    repeat (200) @(negedge clk);
    check("k9_hold_entry", entry_value, 16'h0009);
    check("k9_hold_valid", {15'd0, key_valid}, 16'd1);
    check("k9_no_overrun", overrun_cnt[15:0], 16'd0);
    ack_pulse("k9_ack");
    contact = 1'b0;
    repeat (64) @(negedge clk);

    // Digit entry sequence
    do_key(4'h1, "d1");
    do_key(4'hA, "dA");
    do_key(4'h3, "d3");
    do_key(4'hF, "dF");
    check("entry_1A3F", entry_value, 16'h1A3F);
    do_key(4'h0, "d0");
    check("entry_A3F0", entry_value, 16'hA3F0);

    // Plain entry clear
    entry_clear = 1'b1;
    @(negedge clk);
    entry_clear = 1'b0;
    check("entry_clear", entry_value, 16'h0000);

    // Bouncing press then stable key 5: exactly one accept
    key_sel = 4'd5;
    contact = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) contact = ~contact;
      @(negedge clk);
    end
    contact = 1'b1;
    repeat (160) @(negedge clk);
    check("bounce_valid", {15'd0, key_valid}, 16'd1);
    check("bounce_code", {12'd0, key_code}, 16'd5);
    check("bounce_entry", entry_value, 16'h0005);
    ack_pulse("bounce_ack");
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) contact = ~contact;
      @(negedge clk);
    end
    contact = 1'b0;
    repeat (64) @(negedge clk);
    check("bounce_rel_valid", {15'd0, key_valid}, 16'd0);
    check("bounce_rel_entry", entry_value, 16'h0005);

    // Overrun: key 2 unacked, then key 7
    ov0 = overrun_cnt;
    key_sel = 4'd2;
    contact = 1'b1;
    wait_valid();
    check("ov_k2_code", {12'd0, key_code}, 16'd2);
    contact = 1'b0;
    repeat (64) @(negedge clk);
    check("ov_k2_pending", {15'd0, key_valid}, 16'd1);
    key_sel = 4'd7;
    contact = 1'b1;
    for (int n = 0; n < 51 && key_code !== 4'd7; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("ov_k7_code", {12'd0, key_code}, 16'd7);
    check("ov_k7_valid", {15'd0, key_valid}, 16'd1);
    check("ov_pulse_count", 16'(overrun_cnt - ov0), 16'd1);
    ack_pulse("ov_ack");
    contact = 1'b0;
    repeat (64) @(negedge clk);

    // Ack coincident with accept: new key wins, no overrun
    ov0 = overrun_cnt;
    key_sel = 4'd2;
    contact = 1'b1;
    wait_valid();
    check("co_k2_code", {12'd0, key_code}, 16'd2);
    contact = 1'b0;
    repeat (64) @(negedge clk);
    align_frame(base);
    key_sel = 4'd7;
    contact = 1'b1;
    wait_cyc(base + 31);
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    check("co_k7_valid", {15'd0, key_valid}, 16'd1);
    check("co_k7_code", {12'd0, key_code}, 16'd7);
    repeat (3) @(negedge clk);
    check("co_no_overrun", 16'(overrun_cnt - ov0), 16'd0);
    ack_pulse("co_ack");
    contact = 1'b0;
    repeat (64) @(negedge clk);

    // entry_clear coincident with accept of key 4
    align_frame(base);
    key_sel = 4'd4;
    contact = 1'b1;
    wait_cyc(base + 31);
    entry_clear = 1'b1;
    @(negedge clk);
    entry_clear = 1'b0;
    check("clr_acc_entry", entry_value, 16'h0004);
    check("clr_acc_code", {12'd0, key_code}, 16'd4);
    check("clr_acc_valid", {15'd0, key_valid}, 16'd1);
    contact = 1'b0;
    repeat (64) @(negedge clk);

    // Reset pulse mid-debounce of key 6
    align_frame(base);
    key_sel = 4'd6;
    contact = 1'b1;
    repeat (20) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {15'd0, key_valid}, 16'd0);
    check("mid_rst_code", {12'd0, key_code}, 16'd0);
    check("mid_rst_entry", entry_value, 16'h0000);
    check("mid_rst_overrun", {15'd0, key_overrun}, 16'd0);
    check("mid_rst_rows", {12'd0, rows_n}, 16'h000E);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rows", {12'd0, rows_n}, 16'h000E);
    wait_cyc(31);
    check("post_rst_not_yet", {15'd0, key_valid}, 16'd0);
    @(negedge clk);
    check("post_rst_valid", {15'd0, key_valid}, 16'd1);
    check("post_rst_code", {12'd0, key_code}, 16'd6);
    check("post_rst_entry", entry_value, 16'h0006);
    contact = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
